// File: rtl/mem_bus_ctrl.sv
// Memory/IO bus controller: multi-cycle accesses from the CPU FSM to a synchronous RAM,
// a write-only LED register and a read-only switch port, with a one-cycle completion pulse.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RAM_DEPTH = 256,
    parameter int unsigned RAM_WAIT  = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              bus_err,
    output logic [7:0]        ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [7:0]        sw,
    output logic [7:0]        ledr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LP_RAM_LIM = RAM_DEPTH[ADDR_W:0];
    localparam logic [3:0]      LP_WAIT    = RAM_WAIT[3:0];

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_is_wr;
    logic [DATA_W-1:0]   r_read_data;
    logic                r_bus_err;
    logic [7:0]          r_ram_addr;
    logic [DATA_W-1:0]   r_ram_din;
    logic [7:0]          r_ledr;

    logic                w_rd;
    logic                w_wr;
    logic                w_accept;
    logic                w_in_ram;
    logic                w_led_hit;
    logic                w_sw_hit;

    always_comb begin
        w_rd      = (mem_cmd == 2'b01);
        w_wr      = (mem_cmd == 2'b10);
        w_accept  = (r_state == S_IDLE) && (w_rd || w_wr);
        w_in_ram  = ({1'b0, mem_addr} < LP_RAM_LIM);
        w_led_hit = w_wr && (mem_addr == LED_ADDR);
        w_sw_hit  = w_rd && (mem_addr == SW_ADDR);
    end

    // Handshake outputs come from registered state only, so mem_cmd never reaches mem_ready.
    always_comb begin
        w_next    = r_state;
        mem_busy  = (r_state != S_IDLE);
        mem_ready = 1'b0;
        ram_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_in_ram ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    ram_we = r_is_wr;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                mem_ready = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_read_data <= '0;
            r_bus_err   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ledr      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_wr    <= w_wr;
                        r_ram_addr <= mem_addr[7:0];
                        r_ram_din  <= write_data;
                        if (w_in_ram) begin
                            r_cnt <= LP_WAIT;
                        end else if (w_led_hit) begin
                            r_ledr <= write_data[7:0];
                        end else if (w_sw_hit) begin
                            r_read_data <= {{(DATA_W-8){1'b0}}, sw};
                        end else begin
                            r_bus_err <= 1'b1;
                            if (w_rd) begin
                                r_read_data <= '0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_is_wr) begin
                        r_read_data <= ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_data = r_read_data;
    assign bus_err   = r_bus_err;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ledr      = r_ledr;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: behavioural synchronous RAM plus hand-computed
// expectations for reset, RAM/LED/switch/unmapped accesses and reset abort.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;
    logic        mem_busy;
    logic        bus_err;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic [7:0]  sw;
    logic [7:0]  ledr;

    logic [15:0] ram_mem [0:255];
    int          we_cnt;
    int          rdy_cnt;
    int          n_checks;
    int          n_fail;
    int          we0;
    int          rdy0;

    mem_bus_ctrl #(
        .ADDR_W   (9),
        .DATA_W   (16),
        .RAM_DEPTH(256),
        .RAM_WAIT (1),
        .LED_ADDR (9'h100),
        .SW_ADDR  (9'h140)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .write_data(write_data),
        .read_data (read_data),
        .mem_ready (mem_ready),
        .mem_busy  (mem_busy),
        .bus_err   (bus_err),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .sw        (sw),
        .ledr      (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we === 1'b1) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    initial begin
        we_cnt  = 0;
        rdy_cnt = 0;
    end

    always @(posedge clk) begin
        if (ram_we === 1'b1)    we_cnt  <= we_cnt + 1;
        if (mem_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".read_data"}, 32'(read_data), 32'h0);
        chk({tag, ".mem_ready"}, 32'(mem_ready), 32'h0);
        chk({tag, ".mem_busy"},  32'(mem_busy),  32'h0);
        chk({tag, ".bus_err"},   32'(bus_err),   32'h0);
        chk({tag, ".ram_we"},    32'(ram_we),    32'h0);
        chk({tag, ".ram_addr"},  32'(ram_addr),  32'h0);
        chk({tag, ".ram_din"},   32'(ram_din),   32'h0);
        chk({tag, ".ledr"},      32'(ledr),      32'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = '0;
        write_data = '0;
        sw         = 8'h00;

        repeat (2) tick();
        chk_reset_vals("por");
        reset = 1'b0;
        tick();

        // T2: RAM write 16'h1234 @ 9'h005
        we0 = we_cnt;
        mem_cmd = 2'b10; mem_addr = 9'h005; write_data = 16'h1234;
        tick();
        chk("wr.n1.busy", 32'(mem_busy), 32'h1);
        chk("wr.n1.ready", 32'(mem_ready), 32'h0);
        chk("wr.n1.we", 32'(ram_we), 32'h0);
        chk("wr.n1.ram_addr", 32'(ram_addr), 32'h05);
        chk("wr.n1.ram_din", 32'(ram_din), 32'h1234);
        tick();
        chk("wr.n2.we", 32'(ram_we), 32'h1);
        chk("wr.n2.ready", 32'(mem_ready), 32'h0);
        tick();
        chk("wr.n3.we", 32'(ram_we), 32'h0);
        chk("wr.n3.ready", 32'(mem_ready), 32'h1);
        chk("wr.n3.busy", 32'(mem_busy), 32'h1);
        mem_cmd = 2'b00;
        tick();
        chk("wr.idle.busy", 32'(mem_busy), 32'h0);
        chk("wr.idle.ready", 32'(mem_ready), 32'h0);
        chk("wr.we_pulses", 32'(we_cnt - we0), 32'h1);
        chk("wr.ram_word", 32'(ram_mem[5]), 32'h1234);

        // T2: RAM read back @ 9'h005
        mem_cmd = 2'b01; mem_addr = 9'h005;
        tick();
        chk("rd.n1.busy", 32'(mem_busy), 32'h1);
        chk("rd.n1.ready", 32'(mem_ready), 32'h0);
        tick();
        chk("rd.n2.busy", 32'(mem_busy), 32'h1);
        chk("rd.n2.ready", 32'(mem_ready), 32'h0);
        chk("rd.n2.we", 32'(ram_we), 32'h0);
        tick();
        chk("rd.n3.ready", 32'(mem_ready), 32'h1);
        chk("rd.n3.busy", 32'(mem_busy), 32'h1);
        chk("rd.n3.data", 32'(read_data), 32'h1234);
        mem_cmd = 2'b00;
        tick();
        chk("rd.idle.busy", 32'(mem_busy), 32'h0);
        chk("rd.hold.data", 32'(read_data), 32'h1234);

        // T3: LED write
        we0 = we_cnt;
        mem_cmd = 2'b10; mem_addr = 9'h100; write_data = 16'h00A5;
        tick();
        chk("led.ready", 32'(mem_ready), 32'h1);
        chk("led.ledr", 32'(ledr), 32'hA5);
        chk("led.data_kept", 32'(read_data), 32'h1234);
        mem_cmd = 2'b00;
        tick();
        chk("led.idle.ready", 32'(mem_ready), 32'h0);
        chk("led.no_we", 32'(we_cnt - we0), 32'h0);
        chk("led.bus_err", 32'(bus_err), 32'h0);

        // T4: switch read
        sw = 8'h3C;
        mem_cmd = 2'b01; mem_addr = 9'h140;
        tick();
        chk("sw.ready", 32'(mem_ready), 32'h1);
        chk("sw.data", 32'(read_data), 32'h003C);
        chk("sw.ledr_kept", 32'(ledr), 32'hA5);
        mem_cmd = 2'b00;
        tick();

        // T5: unmapped read, sticky bus_err
        mem_cmd = 2'b01; mem_addr = 9'h1F0;
        tick();
        chk("err.ready", 32'(mem_ready), 32'h1);
        chk("err.data", 32'(read_data), 32'h0);
        chk("err.bus_err", 32'(bus_err), 32'h1);
        mem_cmd = 2'b00;
        tick();
        mem_cmd = 2'b10; mem_addr = 9'h100; write_data = 16'hFF5A;
        tick();
        chk("err.led.ledr", 32'(ledr), 32'h5A);
        chk("err.sticky1", 32'(bus_err), 32'h1);
        mem_cmd = 2'b00;
        tick();
        mem_cmd = 2'b01; mem_addr = 9'h140;
        tick();
        chk("err.sw.data", 32'(read_data), 32'h003C);
        chk("err.sticky2", 32'(bus_err), 32'h1);
        mem_cmd = 2'b00;
        tick();

        // T1: asynchronous reset mid-cycle
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        reset = 1'b0;
        tick();

        // T6: reset during ACCESS of a write
        we0  = we_cnt;
        rdy0 = rdy_cnt;
        mem_cmd = 2'b10; mem_addr = 9'h005; write_data = 16'hBEEF;
        tick();
        chk("abort.busy_pre", 32'(mem_busy), 32'h1);
        reset   = 1'b1;
        mem_cmd = 2'b00;
        #1;
        chk("abort.busy", 32'(mem_busy), 32'h0);
        chk("abort.we", 32'(ram_we), 32'h0);
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("abort.idle", 32'(mem_busy), 32'h0);
        end
        chk("abort.no_we", 32'(we_cnt - we0), 32'h0);
        chk("abort.no_ready", 32'(rdy_cnt - rdy0), 32'h0);
        chk("abort.ram_word", 32'(ram_mem[5]), 32'h1234);

        // T6: command 2'b11 is not accepted
        mem_cmd = 2'b11; mem_addr = 9'h005;
        repeat (3) begin
            tick();
            chk("cmd11.busy", 32'(mem_busy), 32'h0);
            chk("cmd11.ready", 32'(mem_ready), 32'h0);
        end
        mem_cmd = 2'b00;
        tick();

        // RAM still readable after the aborted write
        mem_cmd = 2'b01; mem_addr = 9'h005;
        repeat (3) tick();
        chk("post.ready", 32'(mem_ready), 32'h1);
        chk("post.data", 32'(read_data), 32'h1234);
        mem_cmd = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
